// File: rtl/proc_pkg.sv
// Shared processor definitions: default fetch geometry, opcode encodings and
// instruction field positions used by fetch and decode.
package proc_pkg;

  localparam int DEF_RAM_WIDTH     = 32;
  localparam int DEF_RAM_ADDR_BITS = 9;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_PROG_END_ADDR = 8;

  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] SUB  = 5'd1;
  localparam logic [4:0] MUL  = 5'd2;
  localparam logic [4:0] NAND = 5'd3;
  localparam logic [4:0] LW   = 5'd4;
  localparam logic [4:0] SW   = 5'd5;

  localparam int OPCODE_MSB    = 31;
  localparam int OPCODE_LSB    = 27;
  localparam int RD_MSB        = 26;
  localparam int RD_LSB        = 22;
  localparam int RS1_MSB       = 21;
  localparam int RS1_LSB       = 17;
  localparam int RS2_MSB       = 16;
  localparam int RS2_LSB       = 12;
  localparam int DMEM_ADDR_MSB = 8;
  localparam int DMEM_ADDR_LSB = 0;

  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: program BRAM read port plus the decoded-instruction
// output stream towards decode.
interface instr_fetch_unit_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
);
  logic                     imem_en;
  logic [RAM_ADDR_BITS-1:0] imem_addr;
  logic [RAM_WIDTH-1:0]     imem_rdata;

  // Output stream: a beat transfers on any clock edge where out_valid && out_ready.
  // out_valid never depends on out_ready, and out_instr/out_pc hold steady while
  // out_valid is high and out_ready is low.
  logic                     out_valid;
  logic                     out_ready;
  logic [RAM_WIDTH-1:0]     out_instr;
  logic [RAM_ADDR_BITS-1:0] out_pc;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with occupancy count and single-cycle flush; storage
// is reset so the head reads zero out of reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch: walks the PC through the program BRAM, tags each
// returned word with its address and buffers it for decode; supports redirect and halt.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int PC_RESET      = 0,
  parameter int PROG_END_ADDR = DEF_PROG_END_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_fetch_unit_if.master       bus,
  input  logic                     redirect_valid,
  input  logic [RAM_ADDR_BITS-1:0] redirect_addr,
  output logic                     halted
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = RAM_ADDR_BITS + RAM_WIDTH;
  localparam logic [RAM_ADDR_BITS:0]   END_PC   = (RAM_ADDR_BITS + 1)'(PROG_END_ADDR);
  localparam logic [RAM_ADDR_BITS-1:0] START_PC = RAM_ADDR_BITS'(PC_RESET);
  localparam logic [CNT_W:0]           CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

  logic [RAM_ADDR_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [RAM_ADDR_BITS-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic                     halted_q, halted_d;

  logic                     req;
  logic                     past_end;
  logic                     push;
  logic                     pop;
  logic                     out_valid;
  logic [ENTRY_W-1:0]       push_data;
  logic [ENTRY_W-1:0]       fifo_head;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;

  always_comb begin
    past_end = ({1'b0, fetch_pc_q} > END_PC);
    // Buffered plus in-flight words never exceed the FIFO depth, so a push
    // always finds a free slot.
    req = !reset && !redirect_valid && !past_end &&
          (({1'b0, fifo_count} + (CNT_W + 1)'(inflight_q)) < CREDITS);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + RAM_ADDR_BITS'(1);
    end

    inflight_d    = req;
    inflight_pc_d = req ? fetch_pc_q : inflight_pc_q;

    // The word returning during a redirect belongs to the old path and is dropped.
    push      = inflight_q && !redirect_valid;
    push_data = {inflight_pc_q, bus.imem_rdata};

    out_valid = !fifo_empty;
    pop       = out_valid && bus.out_ready;

    halted_d = 1'b0;
    if (!redirect_valid) begin
      halted_d = halted_q || (past_end && fifo_empty && !inflight_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= START_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.imem_en   = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = fifo_head[ENTRY_W-1:RAM_WIDTH];
  assign bus.out_instr = fifo_head[RAM_WIDTH-1:0];
  assign halted        = halted_q;

endmodule
